// File: rtl/conv_window_scheduler_if.sv
// conv_window_scheduler_if: feature-buffer read port and MAC window handshake
interface conv_window_scheduler_if #(
   parameter int WIDTH = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int DIM_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic mac_valid;
   logic mac_ready;
   logic mac_clear;
   logic [KERNEL_SIZE*KERNEL_SIZE*WIDTH-1:0] mac_window;
   logic [WIDTH/2:0] mac_q_shift;
   logic [DIM_WIDTH-1:0] out_row;
   logic [DIM_WIDTH-1:0] out_col;
   modport master(output rd_en, rd_addr, mac_valid, mac_clear, mac_window, mac_q_shift, out_row, out_col,
                  input rd_data, mac_ready);
   modport slave(input rd_en, rd_addr, mac_valid, mac_clear, mac_window, mac_q_shift, out_row, out_col,
                 output rd_data, mac_ready);
endinterface

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: row-major KxK window fetch/issue for valid stride-1 conv; SCHED_COL_REUSE_EN reuses columns
module conv_window_scheduler #(
   parameter int WIDTH = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int DIM_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic [DIM_WIDTH-1:0] cfg_img_w,
   input  logic [DIM_WIDTH-1:0] cfg_img_h,
   input  logic [WIDTH/2:0] cfg_q_shift,
   output logic busy,
   output logic done,
   output logic err,
   conv_window_scheduler_if.master bus
);
   localparam int N = KERNEL_SIZE * KERNEL_SIZE;
   localparam int SW = $clog2(N + 1);
   localparam logic [DIM_WIDTH-1:0] KD = DIM_WIDTH'(KERNEL_SIZE);
   localparam logic [DIM_WIDTH-1:0] KM = DIM_WIDTH'(KERNEL_SIZE - 1);
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, ADVANCE, DONE} state_t;
   state_t state, nxt;
   logic [DIM_WIDTH-1:0] w, h, row, col, ky, kx;
   logic [WIDTH/2:0] qs;
   logic [SW-1:0] cnt, nrd, slot, cap_slot;
   logic cap_en, part, last_col, last_row, bad;
   logic [N-1:0][WIDTH-1:0] win;
   logic [ADDR_WIDTH-1:0] addr;
   always_comb begin
      bad = cfg_img_w < KD || cfg_img_h < KD;
      last_col = col == w - KD;
      last_row = row == h - KD;
      nrd = part ? SW'(KERNEL_SIZE) : SW'(N);
      slot = SW'(ky) * SW'(KERNEL_SIZE) + SW'(kx);
      addr = (ADDR_WIDTH'(row) + ADDR_WIDTH'(ky)) * ADDR_WIDTH'(w) + ADDR_WIDTH'(col) + ADDR_WIDTH'(kx);
   end
   always_ff @(posedge clk) state <= reset ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? (bad ? DONE : FETCH) : IDLE;
         FETCH:   nxt = cnt == nrd ? ISSUE : FETCH;
         ISSUE:   nxt = bus.mac_ready ? ADVANCE : ISSUE;
         ADVANCE: nxt = last_col && last_row ? DONE : FETCH;
         default: nxt = IDLE;
      endcase
   end
   assign busy = state inside {FETCH, ISSUE, ADVANCE};
   assign done = state == DONE;
   assign bus.rd_en = state == FETCH && cnt < nrd;
   assign bus.rd_addr = bus.rd_en ? addr : '0;
   assign bus.mac_valid = state == ISSUE;
   assign bus.mac_clear = bus.mac_valid;
   assign bus.mac_window = win;
   assign bus.mac_q_shift = qs;
   assign bus.out_row = row;
   assign bus.out_col = col;
   // rd_data belongs to the read issued last cycle; cap_en/cap_slot track it so reset drops it
   always_ff @(posedge clk) begin
      if (reset) begin
         {w, h, row, col, ky, kx, qs, cnt, cap_slot, cap_en, part, err} <= '0;
         win <= '0;
      end else begin
         cap_en <= bus.rd_en;
         cap_slot <= slot;
         if (cap_en) win[cap_slot] <= bus.rd_data;
         case (state)
            IDLE: if (start) begin
               w <= cfg_img_w;
               h <= cfg_img_h;
               qs <= cfg_q_shift;
               {row, col, ky, kx, cnt, part} <= '0;
               err <= bad;
            end
            FETCH: if (bus.rd_en) begin
               cnt <= cnt + 1'b1;
               if (part || kx == KM) begin
                  kx <= part ? KM : '0;
                  ky <= ky + 1'b1;
               end else kx <= kx + 1'b1;
            end
            ADVANCE: begin
               cnt <= '0;
               ky <= '0;
               if (last_col) begin
                  col <= '0;
                  row <= row + 1'b1;
                  kx <= '0;
                  part <= 1'b0;
               end else begin
                  col <= col + 1'b1;
`ifdef SCHED_COL_REUSE_EN
                  part <= 1'b1;
                  kx <= KM;
                  for (int r = 0; r < KERNEL_SIZE; r++)
                     for (int c = 0; c < KERNEL_SIZE - 1; c++)
                        win[r*KERNEL_SIZE+c] <= win[r*KERNEL_SIZE+c+1];
`else
                  kx <= '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: scoreboard bench for conv_window_scheduler
module tb_conv_window_scheduler;
   typedef struct {int r; int c; logic [71:0] win;} exp_t;
`ifdef SCHED_COL_REUSE_EN
   localparam int RD1 = 24, RD3 = 15, LAT1 = 37;
`else
   localparam int RD1 = 36, RD3 = 27, LAT1 = 49;
`endif
   logic clk = 0, reset = 1, start = 0;
   logic [7:0] cfg_img_w = 0, cfg_img_h = 0;
   logic [4:0] cfg_q_shift = 0, cur_q = 0;
   logic busy, done, err;
   int errors = 0, checks = 0, cyc = 0, ndone = 0, nvalid = 0, nwin = 0, t0 = 0, lat = 0;
   int raddr[$];
   exp_t sb[$];
   exp_t e;
   int fa[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   logic [127:0] snap;
   bit seen;
   always #5 clk = ~clk;
   conv_window_scheduler_if bus();
   conv_window_scheduler dut(.clk(clk), .reset(reset), .start(start), .cfg_img_w(cfg_img_w),
      .cfg_img_h(cfg_img_h), .cfg_q_shift(cfg_q_shift), .busy(busy), .done(done), .err(err), .bus(bus));
   function automatic logic [7:0] pix(input int a);
      return 8'(a * 37 + 11);
   endfunction
   function automatic logic [71:0] exp_win(input int w, input int r, input int c);
      logic [71:0] v = '0;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 3; x++) v[(y*3+x)*8 +: 8] = pix((r + y) * w + c + x);
      return v;
   endfunction
   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   function automatic logic [127:0] outs();
      return {13'd0, busy, done, err, bus.rd_en, bus.rd_addr, bus.mac_valid, bus.mac_clear,
              bus.mac_window, bus.mac_q_shift, bus.out_row, bus.out_col};
   endfunction
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.rd_en) bus.rd_data <= pix(int'(bus.rd_addr));
   end
   always @(negedge clk) begin
      if (done) ndone++;
      if (bus.rd_en) raddr.push_back(int'(bus.rd_addr));
      if (bus.mac_valid) nvalid++;
      if (bus.mac_valid && bus.mac_ready) begin
         nwin++;
         if (sb.size() == 0) chk("unexpected_window", 1, 0);
         else begin
            e = sb.pop_front();
            chk("out_row", bus.out_row, e.r);
            chk("out_col", bus.out_col, e.c);
            chk("mac_window", bus.mac_window, e.win);
            chk("mac_clear", bus.mac_clear, 1);
            chk("mac_q_shift", bus.mac_q_shift, cur_q);
         end
      end
   end
   task automatic clear();
      raddr.delete();
      ndone = 0;
      nvalid = 0;
      nwin = 0;
   endtask
   task automatic kick(input int w, input int h, input logic [4:0] q);
      @(posedge clk);
      #1;
      cfg_img_w = 8'(w);
      cfg_img_h = 8'(h);
      cfg_q_shift = q;
      cur_q = q;
      for (int r = 0; r <= h - 3; r++)
         for (int c = 0; c <= w - 3; c++) sb.push_back('{r, c, exp_win(w, r, c)});
      start = 1;
      t0 = cyc;
      @(posedge clk);
      #1 start = 0;
   endtask
   task automatic wait_done(output int l);
      l = -1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            l = cyc - t0;
            @(negedge clk);
            chk("done_width", done, 0);
            return;
         end
      end
      chk("done_timeout", 0, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.mac_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", outs(), 0);
      @(posedge clk);
      #1 reset = 0;
      // full map, MAC always ready
      bus.mac_ready = 1;
      clear();
      kick(4, 4, 5);
      @(negedge clk);
      chk("busy_after_start", busy, 1);
      wait_done(lat);
      chk("t1_latency", lat, LAT1);
      chk("t1_reads", raddr.size(), RD1);
      for (int i = 0; i < 9; i++) chk($sformatf("t1_addr%0d", i), raddr[i], fa[i]);
`ifdef SCHED_COL_REUSE_EN
      chk("t2_reuse_addr0", raddr[9], 3);
      chk("t2_reuse_addr1", raddr[10], 7);
      chk("t2_reuse_addr2", raddr[11], 11);
`endif
      chk("t1_err", err, 0);
      chk("t1_done_count", ndone, 1);
      chk("t1_windows", nwin, 4);
      chk("t1_sb_empty", sb.size(), 0);
      // stall at first ISSUE
      bus.mac_ready = 0;
      clear();
      kick(5, 3, 2);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = bus.mac_valid;
      end
      chk("t3_valid_seen", seen, 1);
      snap = {bus.mac_valid, bus.mac_window, bus.out_row, bus.out_col};
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t3_stable%0d", i), {bus.mac_valid, bus.mac_window, bus.out_row, bus.out_col}, snap);
      end
      @(posedge clk);
      #1 bus.mac_ready = 1;
      wait_done(lat);
      chk("t3_windows", nwin, 3);
      chk("t3_reads", raddr.size(), RD3);
      chk("t3_sb_empty", sb.size(), 0);
      // undersized image
      clear();
      kick(2, 4, 1);
      @(negedge clk);
      chk("t4_done", done, 1);
      chk("t4_err", err, 1);
      chk("t4_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("t4_err_sticky", err, 1);
      chk("t4_no_reads", raddr.size(), 0);
      chk("t4_no_valid", nvalid, 0);
      chk("t4_done_count", ndone, 1);
      // reset during fetch of window (0,1)
      clear();
      kick(4, 4, 3);
      @(negedge clk);
      chk("t5_err_cleared", err, 0);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = bus.rd_en && bus.out_col == 1;
      end
      chk("t5_fetch_seen", seen, 1);
      @(posedge clk);
      #1 reset = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_reset_outputs", outs(), 0);
      sb.delete();
      @(posedge clk);
      #1 reset = 0;
      clear();
      kick(3, 3, 4);
      wait_done(lat);
      chk("t5_windows", nwin, 1);
      chk("t5_sb_empty", sb.size(), 0);
      chk("t5_done_count", ndone, 1);
      // second start while busy, cfg changed mid-run
      clear();
      kick(4, 4, 5);
      @(posedge clk);
      #1;
      start = 1;
      cfg_img_w = 3;
      cfg_img_h = 3;
      cfg_q_shift = 7;
      @(posedge clk);
      #1 start = 0;
      wait_done(lat);
      chk("t6_latency", lat, LAT1);
      chk("t6_windows", nwin, 4);
      chk("t6_sb_empty", sb.size(), 0);
      chk("t6_done_count", ndone, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
